// File: rtl/pool_window_seq.sv
// Window-order frame source for max-pool: walks a row-major feature map in SRAM
// one POOLxPOOL window at a time and frames each element for the pooling unit.
module pool_window_seq #(
    parameter int WD        = 8,
    parameter int INPUT_NUM = 6,
    parameter int FMAP_W    = 28,
    parameter int FMAP_H    = 28,
    parameter int POOL      = 2,
    parameter int ADDR_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [WD*INPUT_NUM-1:0] rd_data,
    output logic                    aa_en,
    output logic                    aa_first_data,
    output logic                    aa_last_data,
    output logic [WD*INPUT_NUM-1:0] data_o
);

    localparam int NWX = FMAP_W / POOL;
    localparam int NWY = FMAP_H / POOL;
    localparam int KW  = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int XW  = (NWX > 1) ? $clog2(NWX) : 1;
    localparam int YW  = (NWY > 1) ? $clog2(NWY) : 1;

    localparam logic [KW-1:0] K_MAX = KW'(POOL - 1);
    localparam logic [XW-1:0] X_MAX = XW'(NWX - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(NWY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic          kx_wrap;
    logic          ky_wrap;
    logic          wx_wrap;
    logic          wy_wrap;
    logic          last_read;

    assign kx_wrap   = (kx == K_MAX);
    assign ky_wrap   = (ky == K_MAX);
    assign wx_wrap   = (wx == X_MAX);
    assign wy_wrap   = (wy == Y_MAX);
    assign last_read = kx_wrap && ky_wrap && wx_wrap && wy_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (last_read) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    // Counters freeze on the final read so rd_addr keeps pointing at it afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx <= '0;
            ky <= '0;
            wx <= '0;
            wy <= '0;
        end else if (clear || (state == IDLE && start)) begin
            kx <= '0;
            ky <= '0;
            wx <= '0;
            wy <= '0;
        end else if (state == RUN && !last_read) begin
            if (!kx_wrap) begin
                kx <= kx + KW'(1);
            end else begin
                kx <= '0;
                if (!ky_wrap) begin
                    ky <= ky + KW'(1);
                end else begin
                    ky <= '0;
                    if (!wx_wrap) begin
                        wx <= wx + XW'(1);
                    end else begin
                        wx <= '0;
                        wy <= wy + YW'(1);
                    end
                end
            end
        end
    end

    assign rd_addr = ADDR_W'((int'(wy) * POOL + int'(ky)) * FMAP_W
                             + int'(wx) * POOL + int'(kx));

    // Framing is delayed one cycle to line up with the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aa_en         <= 1'b0;
            aa_first_data <= 1'b0;
            aa_last_data  <= 1'b0;
        end else if (clear) begin
            aa_en         <= 1'b0;
            aa_first_data <= 1'b0;
            aa_last_data  <= 1'b0;
        end else begin
            aa_en         <= rd_en;
            aa_first_data <= rd_en && (kx == '0) && (ky == '0);
            aa_last_data  <= rd_en && kx_wrap && ky_wrap;
        end
    end

    assign data_o = aa_en ? rd_data : '0;

endmodule

// File: tb/tb_pool_window_seq.sv
// Directed bench: 4x4 and 5x5 instances checked cycle by cycle, 28x28 instance
// checked for latency, beat count and window count.
module tb_pool_window_seq;

    localparam int DW = 48;
    localparam int EXP4 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    localparam int EXP5 [16] = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};

    logic clk;
    logic rst_n;
    logic start;
    logic clear;

    logic          busy4, done4, rd_en4, aa_en4, first4, last4;
    logic [3:0]    rd_addr4;
    logic [DW-1:0] rd_data4, data4;
    logic          busy5, done5, rd_en5, aa_en5, first5, last5;
    logic [4:0]    rd_addr5;
    logic [DW-1:0] rd_data5, data5;
    logic          busy28, done28, rd_en28, aa_en28, first28, last28;
    logic [9:0]    rd_addr28;
    logic [DW-1:0] rd_data28, data28;

    int total;
    int bad;

    pool_window_seq #(.WD(8), .INPUT_NUM(6), .FMAP_W(4), .FMAP_H(4), .POOL(2), .ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4), .aa_en(aa_en4),
        .aa_first_data(first4), .aa_last_data(last4), .data_o(data4)
    );

    pool_window_seq #(.WD(8), .INPUT_NUM(6), .FMAP_W(5), .FMAP_H(5), .POOL(2), .ADDR_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .busy(busy5), .done(done5),
        .rd_en(rd_en5), .rd_addr(rd_addr5), .rd_data(rd_data5), .aa_en(aa_en5),
        .aa_first_data(first5), .aa_last_data(last5), .data_o(data5)
    );

    pool_window_seq #(.WD(8), .INPUT_NUM(6), .FMAP_W(28), .FMAP_H(28), .POOL(2), .ADDR_W(10)) dut28 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .busy(busy28), .done(done28),
        .rd_en(rd_en28), .rd_addr(rd_addr28), .rd_data(rd_data28), .aa_en(aa_en28),
        .aa_first_data(first28), .aa_last_data(last28), .data_o(data28)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {16'hC35A ^ a16, a16 * 16'd7, ~a16};
    endfunction

    // 1-cycle-latency SRAM models
    always @(posedge clk) if (rd_en4) rd_data4 <= pattern(int'(rd_addr4));
    always @(posedge clk) if (rd_en5) rd_data5 <= pattern(int'(rd_addr5));
    always @(posedge clk) if (rd_en28) rd_data28 <= pattern(int'(rd_addr28));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Inputs change on the falling edge and are sampled by the next rising edge.
    task automatic applyStimulus(input logic s, input logic c);
        start = s;
        clear = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Cycle k counts from the first cycle after the edge that sampled start.
    task automatic checkCycle(input int k);
        logic en, aa, fst, lst;
        int b, a4, a5;
        logic [DW-1:0] d4, d5;
        en  = (k >= 1 && k <= 16);
        aa  = (k >= 2 && k <= 17);
        b   = aa ? k - 2 : 0;
        fst = aa && (b % 4 == 0);
        lst = aa && (b % 4 == 3);
        a4  = 15;
        a5  = 18;
        if (en) begin
            a4 = EXP4[k-1];
            a5 = EXP5[k-1];
        end
        d4 = aa ? pattern(EXP4[b]) : '0;
        d5 = aa ? pattern(EXP5[b]) : '0;
        checkOutput("rd_en4", 64'(rd_en4), 64'(en));
        checkOutput("rd_addr4", 64'(rd_addr4), 64'(a4));
        checkOutput("aa_en4", 64'(aa_en4), 64'(aa));
        checkOutput("first4", 64'(first4), 64'(fst));
        checkOutput("last4", 64'(last4), 64'(lst));
        checkOutput("data4", 64'(data4), 64'(d4));
        checkOutput("busy4", 64'(busy4), 64'(k >= 1 && k <= 17));
        checkOutput("done4", 64'(done4), 64'(k == 18));
        checkOutput("rd_en5", 64'(rd_en5), 64'(en));
        checkOutput("rd_addr5", 64'(rd_addr5), 64'(a5));
        checkOutput("aa_en5", 64'(aa_en5), 64'(aa));
        checkOutput("data5", 64'(data5), 64'(d5));
    endtask

    task automatic runFrame(input int pulse_k, input int clear_k, input int stop_k);
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= stop_k; k++) begin
            checkCycle(k);
            applyStimulus((k == pulse_k) || (k == clear_k), k == clear_k);
        end
    endtask

    int first_k, done_k, beats, rises, dones, firsts, lasts;
    logic prev_aa;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy4), 64'(0));
        checkOutput("rst_done", 64'(done4), 64'(0));
        checkOutput("rst_rd_en", 64'(rd_en4), 64'(0));
        checkOutput("rst_rd_addr", 64'(rd_addr4), 64'(0));
        checkOutput("rst_aa_en", 64'(aa_en4), 64'(0));
        checkOutput("rst_data", 64'(data4), 64'(0));
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_rd_en", 64'(rd_en4), 64'(0));

        // First frame: all three sizes start together
        first_k = -1; done_k = -1; beats = 0; rises = 0; dones = 0; firsts = 0; lasts = 0;
        prev_aa = 1'b0;
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 800; k++) begin
            if (k <= 20) checkCycle(k);
            if (aa_en28) begin
                beats++;
                if (first_k < 0) first_k = k;
                if (!prev_aa) rises++;
                if (first28) firsts++;
                if (last28) lasts++;
            end
            if (done28) begin
                dones++;
                done_k = k;
            end
            prev_aa = aa_en28;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("first_beat28", 64'(first_k), 64'(2));
        checkOutput("beats28", 64'(beats), 64'(784));
        checkOutput("contig28", 64'(rises), 64'(1));
        checkOutput("windows28", 64'(firsts), 64'(196));
        checkOutput("lasts28", 64'(lasts), 64'(196));
        checkOutput("dones28", 64'(dones), 64'(1));
        checkOutput("done_at28", 64'(done_k), 64'(786));

        // start re-pulsed at beat 5 is ignored; a start after done runs a full frame
        runFrame(7, 0, 20);
        runFrame(0, 0, 20);

        // clear at beat 6 with a simultaneous start
        runFrame(0, 8, 8);
        checkOutput("clr_busy", 64'(busy4), 64'(0));
        checkOutput("clr_aa_en", 64'(aa_en4), 64'(0));
        checkOutput("clr_rd_en", 64'(rd_en4), 64'(0));
        checkOutput("clr_done", 64'(done4), 64'(0));
        checkOutput("clr_busy28", 64'(busy28), 64'(0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("clr_after_done", 64'(done4), 64'(0));
            checkOutput("clr_after_rd_en", 64'(rd_en4), 64'(0));
            checkOutput("clr_after_aa_en", 64'(aa_en4), 64'(0));
        end

        // asynchronous reset at beat 9
        runFrame(0, 0, 10);
        checkCycle(11);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(busy4), 64'(0));
        checkOutput("arst_rd_en", 64'(rd_en4), 64'(0));
        checkOutput("arst_rd_addr", 64'(rd_addr4), 64'(0));
        checkOutput("arst_aa_en", 64'(aa_en4), 64'(0));
        checkOutput("arst_first", 64'(first4), 64'(0));
        checkOutput("arst_last", 64'(last4), 64'(0));
        checkOutput("arst_data", 64'(data4), 64'(0));
        checkOutput("arst_done", 64'(done4), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("post_rst_rd_en", 64'(rd_en4), 64'(0));
            checkOutput("post_rst_aa_en", 64'(aa_en4), 64'(0));
        end
        runFrame(0, 0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
